per2axi_req_arbiter: RTL and testbench

// - Shares one cluster-side peripheral-to-AXI bridge slave port between NB_CORES requesters.
// - Each cycle, picks one eligible request by round-robin and parks it in a one-entry request register.
// - Tags the request with a one-hot core ID and routes each response back by that ID.
// - Limits outstanding transactions per core and reports activity to the cluster busy logic.

---
 rtl/per_arb_pkg.sv | 38 +++
 rtl/per2axi_req_arbiter_if.sv | 52 +++++
 rtl/per_rr_arb.sv | 38 +++
 rtl/per2axi_req_arbiter.sv | 119 +++++++++++
 tb/tb_per2axi_req_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/per_arb_pkg.sv
// rtl/per_arb_pkg.sv - shared types and helpers for the peripheral request arbiter
package per_arb_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int PKG_BE_W   = PKG_DATA_W / 8;
    localparam int PKG_ID_W   = 5;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] add;
        logic                  wen;
        logic [PKG_DATA_W-1:0] wdata;
        logic [PKG_BE_W-1:0]   be;
        logic [PKG_ID_W-1:0]   id;
    } per_req_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } onehot_t;

    // valid only when exactly one bit is set; idx is that bit's position
    function automatic onehot_t onehot_idx(input logic [31:0] vec);
        onehot_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                n++;
                r.idx = 5'(i);
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/per2axi_req_arbiter_if.sv
// rtl/per2axi_req_arbiter_if.sv - core-side and bridge-side bundles of the request arbiter
interface per_core_if #(
    parameter int NB_CORES       = 4,
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_DATA_WIDTH = 32
);
    logic [NB_CORES-1:0]                         core_req_i;
    logic [NB_CORES-1:0][PER_ADDR_WIDTH-1:0]     core_add_i;
    logic [NB_CORES-1:0]                         core_wen_i;
    logic [NB_CORES-1:0][PER_DATA_WIDTH-1:0]     core_wdata_i;
    logic [NB_CORES-1:0][PER_DATA_WIDTH/8-1:0]   core_be_i;
    logic [NB_CORES-1:0]                         core_gnt_o;
    logic [NB_CORES-1:0]                         core_r_valid_o;
    logic [PER_DATA_WIDTH-1:0]                   core_r_rdata_o;
    logic                                        core_r_opc_o;

    modport master (
        output core_req_i, core_add_i, core_wen_i, core_wdata_i, core_be_i,
        input  core_gnt_o, core_r_valid_o, core_r_rdata_o, core_r_opc_o
    );
    modport slave (
        input  core_req_i, core_add_i, core_wen_i, core_wdata_i, core_be_i,
        output core_gnt_o, core_r_valid_o, core_r_rdata_o, core_r_opc_o
    );
endinterface

interface per_bus_if #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_DATA_WIDTH = 32,
    parameter int PER_ID_WIDTH   = 5
);
    logic                        per_req_o;
    logic [PER_ADDR_WIDTH-1:0]   per_add_o;
    logic                        per_wen_o;
    logic [PER_DATA_WIDTH-1:0]   per_wdata_o;
    logic [PER_DATA_WIDTH/8-1:0] per_be_o;
    logic [PER_ID_WIDTH-1:0]     per_id_o;
    logic                        per_gnt_i;
    logic                        per_r_valid_i;
    logic [PER_ID_WIDTH-1:0]     per_r_id_i;
    logic [PER_DATA_WIDTH-1:0]   per_r_rdata_i;
    logic                        per_r_opc_i;

    modport master (
        output per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o,
        input  per_gnt_i, per_r_valid_i, per_r_id_i, per_r_rdata_i, per_r_opc_i
    );
    modport slave (
        input  per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o,
        output per_gnt_i, per_r_valid_i, per_r_id_i, per_r_rdata_i, per_r_opc_i
    );
endinterface

// File: rtl/per_rr_arb.sv
// rtl/per_rr_arb.sv - generic round-robin arbiter; pointer moves past the winner on each grant
module per_rr_arb #(
    parameter int NB_CORES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en,
    input  logic [NB_CORES-1:0] eligible,
    output logic [NB_CORES-1:0] grant
);
    localparam int PW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NB_CORES; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NB_CORES) j = j - NB_CORES;
            if (en && !found && eligible[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
                ptr_d    = (j + 1 == NB_CORES) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/per2axi_req_arbiter.sv
// rtl/per2axi_req_arbiter.sv - shares one bridge slave port between cores with per-core outstanding limits
module per2axi_req_arbiter
    import per_arb_pkg::*;
#(
    parameter int NB_CORES        = 4,
    parameter int PER_ADDR_WIDTH  = 32,
    parameter int PER_DATA_WIDTH  = 32,
    parameter int PER_ID_WIDTH    = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    per_core_if.slave  core,
    per_bus_if.master  per,
    output logic       unexp_rsp_o,
    output logic       busy_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (PER_ID_WIDTH < NB_CORES) begin : g_bad_id_width
        $fatal(1, "PER_ID_WIDTH must be >= NB_CORES");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_max_out
        $fatal(1, "MAX_OUTSTANDING must be >= 1");
    end
    if (PER_ADDR_WIDTH != PKG_ADDR_W || PER_DATA_WIDTH != PKG_DATA_W || PER_ID_WIDTH != PKG_ID_W) begin : g_bad_widths
        $fatal(1, "bus widths must match per_arb_pkg");
    end

    logic [NB_CORES-1:0] elig;
    logic [NB_CORES-1:0] gnt;
    logic [NB_CORES-1:0] rvalid;
    logic [CW-1:0]       cnt_q [NB_CORES];
    logic                any_cnt;
    logic                req_valid_q;
    logic                busy_q;
    logic                slot_free;
    per_req_t            req_q;
    per_req_t            req_d;
    onehot_t             rsp_oh;

    always_comb begin
        elig    = '0;
        any_cnt = 1'b0;
        for (int k = 0; k < NB_CORES; k++) begin
            elig[k] = core.core_req_i[k] && (cnt_q[k] != CW'(MAX_OUTSTANDING));
            any_cnt = any_cnt || (cnt_q[k] != '0);
        end
    end

    // a slot accepted downstream this cycle can be refilled in the same cycle
    assign slot_free = !req_valid_q || per.per_gnt_i;

    per_rr_arb #(.NB_CORES(NB_CORES)) u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en       (slot_free && !rst_i),
        .eligible (elig),
        .grant    (gnt)
    );

    always_comb begin
        req_d    = '0;
        req_d.id = PKG_ID_W'(gnt);
        for (int k = 0; k < NB_CORES; k++) begin
            if (gnt[k]) begin
                req_d.add   = core.core_add_i[k];
                req_d.wen   = core.core_wen_i[k];
                req_d.wdata = core.core_wdata_i[k];
                req_d.be    = core.core_be_i[k];
            end
        end
    end

    // only a one-hot ID naming a core with something outstanding is routed
    always_comb begin
        rsp_oh = onehot_idx(32'(per.per_r_id_i));
        rvalid = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            rvalid[k] = per.per_r_valid_i && !rst_i && rsp_oh.valid &&
                        (rsp_oh.idx == 5'(k)) && (cnt_q[k] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NB_CORES; k++) cnt_q[k] <= '0;
        end else begin
            if (gnt != '0) begin
                req_q       <= req_d;
                req_valid_q <= 1'b1;
            end else if (per.per_gnt_i) begin
                req_valid_q <= 1'b0;
            end
            busy_q <= req_valid_q || any_cnt;
            for (int k = 0; k < NB_CORES; k++) begin
                if (gnt[k] && !rvalid[k])      cnt_q[k] <= cnt_q[k] + 1'b1;
                else if (!gnt[k] && rvalid[k]) cnt_q[k] <= cnt_q[k] - 1'b1;
            end
        end
    end

    assign core.core_gnt_o     = gnt;
    assign core.core_r_valid_o = rvalid;
    assign core.core_r_rdata_o = rst_i ? '0 : per.per_r_rdata_i;
    assign core.core_r_opc_o   = per.per_r_opc_i && !rst_i;
    assign unexp_rsp_o         = per.per_r_valid_i && !rst_i && (rvalid == '0);

    assign per.per_req_o   = req_valid_q && !rst_i;
    assign per.per_add_o   = rst_i ? '0 : req_q.add;
    assign per.per_wen_o   = req_q.wen && !rst_i;
    assign per.per_wdata_o = rst_i ? '0 : req_q.wdata;
    assign per.per_be_o    = rst_i ? '0 : req_q.be;
    assign per.per_id_o    = rst_i ? '0 : req_q.id;
    assign busy_o          = busy_q && !rst_i;
endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// tb/tb_per2axi_req_arbiter.sv - vector table, corner sequences and random run against a queue model
module tb_per2axi_req_arbiter;
    localparam int NB  = 4;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic unexp_rsp;
    logic busy;

    always #5 clk = ~clk;

    per_core_if #(.NB_CORES(NB), .PER_ADDR_WIDTH(32), .PER_DATA_WIDTH(32)) core_bus ();
    per_bus_if  #(.PER_ADDR_WIDTH(32), .PER_DATA_WIDTH(32), .PER_ID_WIDTH(5)) per_bus ();

    per2axi_req_arbiter #(
        .NB_CORES(NB), .PER_ADDR_WIDTH(32), .PER_DATA_WIDTH(32),
        .PER_ID_WIDTH(5), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .core        (core_bus),
        .per         (per_bus),
        .unexp_rsp_o (unexp_rsp),
        .busy_o      (busy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } pend_t;

    int    m_ptr;
    int    m_cnt [NB];
    pend_t m_pend [$];
    logic  m_busy;
    int    acc_q [$];

    logic [3:0]  e_gnt, e_rv;
    logic        e_unexp;
    int          e_gidx, e_rpos;

    logic [31:0] drv_add [NB];
    logic        drv_wen [NB];
    logic [31:0] drv_wdata [NB];
    logic [3:0]  drv_be [NB];
    logic [31:0] drv_rdata;
    logic        drv_opc;

    logic [3:0]  a_gnt, a_rv;
    logic        a_unexp, a_preq, a_busy;
    logic [4:0]  a_pid;
    logic [31:0] a_add;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_pend.delete();
        acc_q.delete();
        for (int k = 0; k < NB; k++) m_cnt[k] = 0;
    endtask

    task automatic model_expect(input logic [3:0] req, input logic pg, input logic rv, input logic [4:0] rid);
        int n;
        e_gnt = '0; e_rv = '0; e_unexp = 1'b0; e_gidx = -1; e_rpos = -1;
        if (rst) return;
        if (rv) begin
            n = 0;
            for (int b = 0; b < 5; b++) if (rid[b]) begin n++; e_rpos = b; end
            if (n == 1 && e_rpos < NB && m_cnt[e_rpos] > 0) e_rv[e_rpos] = 1'b1;
            else begin e_unexp = 1'b1; e_rpos = -1; end
        end
        if (m_pend.size() == 0 || pg) begin
            for (int i = 0; i < NB; i++) begin
                int k;
                k = (m_ptr + i) % NB;
                if (e_gidx < 0 && req[k] && m_cnt[k] < MAX) begin
                    e_gidx   = k;
                    e_gnt[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update(input logic pg);
        logic nb;
        pend_t p;
        if (rst) begin model_reset(); return; end
        nb = (m_pend.size() > 0);
        for (int k = 0; k < NB; k++) if (m_cnt[k] > 0) nb = 1'b1;
        if (m_pend.size() > 0 && pg) begin
            acc_q.push_back(m_pend[0].idx);
            void'(m_pend.pop_front());
        end
        if (e_gidx >= 0) begin
            p.idx = e_gidx; p.add = drv_add[e_gidx]; p.wen = drv_wen[e_gidx];
            p.wdata = drv_wdata[e_gidx]; p.be = drv_be[e_gidx];
            m_pend.push_back(p);
            m_cnt[e_gidx]++;
            m_ptr = (e_gidx + 1) % NB;
        end
        if (e_rpos >= 0) m_cnt[e_rpos]--;
        m_busy = nb;
    endtask

    // inputs applied just after a rising edge, outputs compared on the falling edge
    task automatic cycle(input logic [3:0] req, input logic pg, input logic rv, input logic [4:0] rid);
        logic       e_preq;
        logic [4:0] e_id;
        core_bus.core_req_i = req;
        for (int k = 0; k < NB; k++) begin
            drv_add[k]   = $urandom;
            drv_wen[k]   = 1'($urandom_range(0, 1));
            drv_wdata[k] = $urandom;
            drv_be[k]    = 4'($urandom);
            core_bus.core_add_i[k]   = drv_add[k];
            core_bus.core_wen_i[k]   = drv_wen[k];
            core_bus.core_wdata_i[k] = drv_wdata[k];
            core_bus.core_be_i[k]    = drv_be[k];
        end
        drv_rdata = $urandom;
        drv_opc   = 1'($urandom_range(0, 1));
        per_bus.per_gnt_i     = pg;
        per_bus.per_r_valid_i = rv;
        per_bus.per_r_id_i    = rid;
        per_bus.per_r_rdata_i = drv_rdata;
        per_bus.per_r_opc_i   = drv_opc;
        @(negedge clk);
        model_expect(req, pg, rv, rid);
        a_gnt = core_bus.core_gnt_o; a_rv = core_bus.core_r_valid_o; a_unexp = unexp_rsp;
        a_preq = per_bus.per_req_o; a_pid = per_bus.per_id_o; a_busy = busy; a_add = per_bus.per_add_o;
        e_preq = !rst && m_pend.size() > 0;
        chk("gnt", 64'(a_gnt), 64'(e_gnt));
        chk("r_valid", 64'(a_rv), 64'(e_rv));
        chk("unexp_rsp", 64'(a_unexp), 64'(e_unexp));
        chk("per_req", 64'(a_preq), 64'(e_preq));
        chk("busy", 64'(a_busy), 64'(!rst && m_busy));
        chk("r_rdata", 64'(core_bus.core_r_rdata_o), rst ? 64'(0) : 64'(drv_rdata));
        chk("r_opc", 64'(core_bus.core_r_opc_o), 64'(!rst && drv_opc));
        if (e_preq) begin
            e_id = 5'b00001 << m_pend[0].idx;
            chk("per_id", 64'(a_pid), 64'(e_id));
            chk("per_add", 64'(a_add), 64'(m_pend[0].add));
            chk("per_wen", 64'(per_bus.per_wen_o), 64'(m_pend[0].wen));
            chk("per_wdata", 64'(per_bus.per_wdata_o), 64'(m_pend[0].wdata));
            chk("per_be", 64'(per_bus.per_be_o), 64'(m_pend[0].be));
        end
        @(posedge clk);
        model_update(pg);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] req);
        rst = 1'b1;
        cycle(req, 1'b1, 1'b0, 5'd0);
        cycle(req, 1'b1, 1'b0, 5'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;  logic rv;     logic [4:0] rid;
        logic [3:0] gnt;  logic preq;   logic [4:0] pid;
        logic [3:0] rval; logic unexp;  logic busy;
    } vec_t;

    vec_t tbl [17];
    int   n_gnt0;
    logic [31:0] held_add;

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 5'b00000, 4'b0100, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b1, 5'b00100, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 5'b00100, 4'b0000, 1'b0, 5'b00000, 4'b0100, 1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 5'b00011, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 1'b1, 5'b01000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 5'b00000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b1, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 5'b10000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b0, 5'b00000, 4'b1000, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 5'b01000, 4'b0001, 1'b1, 5'b01000, 4'b1000, 1'b0, 1'b0};
        tbl[11] = '{4'b1111, 1'b1, 5'b00001, 4'b0010, 1'b1, 5'b00001, 4'b0001, 1'b0, 1'b1};
        tbl[12] = '{4'b1111, 1'b1, 5'b00010, 4'b0100, 1'b1, 5'b00010, 4'b0010, 1'b0, 1'b1};
        tbl[13] = '{4'b1111, 1'b1, 5'b00100, 4'b1000, 1'b1, 5'b00100, 4'b0100, 1'b0, 1'b1};
        tbl[14] = '{4'b0000, 1'b1, 5'b01000, 4'b0000, 1'b1, 5'b01000, 4'b1000, 1'b0, 1'b1};
        tbl[15] = '{4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1};
        tbl[16] = '{4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0};

        model_reset();
        @(posedge clk); #1;
        do_reset(4'b1111);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].req, 1'b1, tbl[i].rv, tbl[i].rid);
            chk($sformatf("tbl%0d_gnt", i), 64'(a_gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d_per_req", i), 64'(a_preq), 64'(tbl[i].preq));
            if (tbl[i].preq) chk($sformatf("tbl%0d_per_id", i), 64'(a_pid), 64'(tbl[i].pid));
            chk($sformatf("tbl%0d_r_valid", i), 64'(a_rv), 64'(tbl[i].rval));
            chk($sformatf("tbl%0d_unexp", i), 64'(a_unexp), 64'(tbl[i].unexp));
            chk($sformatf("tbl%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
        end

        // outstanding limit on core 0
        do_reset(4'b0000);
        n_gnt0 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0001, 1'b1, 1'b0, 5'd0);
            if (a_gnt[0]) n_gnt0++;
        end
        chk("limit_grant_count", 64'(n_gnt0), 64'(2));
        cycle(4'b0011, 1'b1, 1'b0, 5'd0);
        chk("limit_core1_granted", 64'(a_gnt), 64'(4'b0010));
        cycle(4'b0001, 1'b1, 1'b1, 5'b00001);
        chk("limit_rsp_cycle_gnt", 64'(a_gnt), 64'(4'b0000));
        chk("limit_rsp_routed", 64'(a_rv), 64'(4'b0001));
        cycle(4'b0001, 1'b1, 1'b0, 5'd0);
        chk("limit_reenabled", 64'(a_gnt), 64'(4'b0001));

        // downstream backpressure holds the register
        do_reset(4'b0000);
        cycle(4'b0011, 1'b0, 1'b0, 5'd0);
        chk("bp_first_gnt", 64'(a_gnt), 64'(4'b0001));
        held_add = drv_add[0];
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0011, 1'b0, 1'b0, 5'd0);
            chk($sformatf("bp%0d_gnt", i), 64'(a_gnt), 64'(4'b0000));
            chk($sformatf("bp%0d_add", i), 64'(a_add), 64'(held_add));
            chk($sformatf("bp%0d_id", i), 64'(a_pid), 64'(5'b00001));
        end
        cycle(4'b0011, 1'b1, 1'b0, 5'd0);
        chk("bp_resume_gnt", 64'(a_gnt), 64'(4'b0010));

        // reset with two outstanding, then a stale response
        do_reset(4'b0000);
        cycle(4'b0001, 1'b1, 1'b0, 5'd0);
        cycle(4'b0001, 1'b1, 1'b0, 5'd0);
        cycle(4'b0000, 1'b1, 1'b0, 5'd0);
        chk("pre_reset_busy", 64'(a_busy), 64'(1));
        rst = 1'b1;
        cycle(4'b1111, 1'b1, 1'b1, 5'b00001);
        chk("in_reset_gnt", 64'(a_gnt), 64'(0));
        chk("in_reset_rv", 64'(a_rv), 64'(0));
        rst = 1'b0;
        cycle(4'b0000, 1'b1, 1'b0, 5'd0);
        chk("post_reset_busy", 64'(a_busy), 64'(0));
        cycle(4'b0000, 1'b1, 1'b1, 5'b00001);
        chk("stale_unexp", 64'(a_unexp), 64'(1));
        chk("stale_rv", 64'(a_rv), 64'(0));

        // random traffic against the model
        do_reset(4'b0000);
        for (int c = 0; c < 600; c++) begin
            logic       rv;
            logic [4:0] rid;
            int         r, sel;
            rv = 1'b0; rid = '0;
            r = $urandom_range(0, 9);
            if (r < 5 && acc_q.size() > 0) begin
                sel = $urandom_range(0, acc_q.size() - 1);
                rv  = 1'b1;
                rid = 5'b00001 << acc_q[sel];
                acc_q.delete(sel);
            end else if (r == 5) begin
                rv  = 1'b1;
                rid = 5'($urandom_range(0, 31));
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle(4'($urandom), ($urandom_range(0, 3) != 0), rv, rid);
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
